serial_receiver: RTL and testbench

// - Receive end of the framed serial link. The transmit end is a shift_register:

---
 rtl/rx_pkg.sv | 21 ++
 rtl/sipo_shifter.sv | 41 ++++
 rtl/serial_receiver.sv | 111 +++++++++++
 tb/tb_serial_receiver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// ============================================================
// Package : rx_pkg
// Shared state encoding and line levels for the serial receiver.
// Rev     : 1.0
// ============================================================
`default_nettype none

package rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sipo_shifter.sv
// ============================================================
// Module : sipo_shifter
// Serial-in parallel-out shift register with selectable bit order.
// Rev    : 1.0
// ============================================================
`default_nettype none

module sipo_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             en,
  input  logic             serial_bit,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // MSB-first pushes in at bit 0 so the first bit ends in the top position.
  if (MSB_FIRST) begin : g_msb_first
    assign w_next = {r_q[WIDTH-2:0], serial_bit};
  end else begin : g_lsb_first
    assign w_next = {serial_bit, r_q[WIDTH-1:1]};
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/serial_receiver.sv
// ============================================================
// Module : serial_receiver
// Framed serial receive end with valid/ready output and sticky errors.
// Rev    : 1.0
// ============================================================
`default_nettype none

module serial_receiver
  import rx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             ready,
  input  logic             err_clear,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             framing_err,
  output logic             overrun_err,
  output logic             busy
);

  localparam int             CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST_BIT = CW'(WIDTH - 1);

  rx_state_t        r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_oerr;

  logic             w_shift_en;
  logic [WIDTH-1:0] w_shift_q;

  assign w_shift_en = bit_en && (r_state == RX_DATA);

  sipo_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clock      (clock),
    .reset_L    (reset_L),
    .en         (w_shift_en),
    .serial_bit (serial_in),
    .q          (w_shift_q)
  );

  // Handshake and error clearing come first so a same-edge event below overrides them.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= RX_IDLE;
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
      if (err_clear) begin
        r_ferr <= 1'b0;
        r_oerr <= 1'b0;
      end
      if (bit_en) begin
        case (r_state)
          RX_IDLE: begin
            if (serial_in == START_BIT) begin
              r_state <= RX_DATA;
              r_count <= '0;
            end
          end
          RX_DATA: begin
            r_count <= r_count + CW'(1);
            if (r_count == C_LAST_BIT) begin
              r_state <= RX_STOP;
            end
          end
          RX_STOP: begin
            r_state <= RX_IDLE;
            if (serial_in == STOP_BIT) begin
              if (!r_valid || ready) begin
                r_data  <= w_shift_q;
                r_valid <= 1'b1;
              end else begin
                r_oerr <= 1'b1;
              end
            end else begin
              r_ferr <= 1'b1;
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign data        = r_data;
  assign data_valid  = r_valid;
  assign framing_err = r_ferr;
  assign overrun_err = r_oerr;
  assign busy        = (r_state != RX_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_receiver.sv
// ============================================================
// Module : tb_serial_receiver
// Bench driving an MSB-first and an LSB-first receiver from one line.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_serial_receiver;

  localparam int W = 8;

  logic         clock;
  logic         reset_L;
  logic         serial_in;
  logic         bit_en;
  logic         ready;
  logic         err_clear;

  logic [W-1:0] m_data, l_data;
  logic         m_valid, l_valid, m_ferr, l_ferr, m_oerr, l_oerr, m_busy, l_busy;

  serial_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset_L(reset_L), .serial_in(serial_in), .bit_en(bit_en),
    .ready(ready), .err_clear(err_clear), .data(m_data), .data_valid(m_valid),
    .framing_err(m_ferr), .overrun_err(m_oerr), .busy(m_busy)
  );

  serial_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset_L(reset_L), .serial_in(serial_in), .bit_en(bit_en),
    .ready(ready), .err_clear(err_clear), .data(l_data), .data_valid(l_valid),
    .framing_err(l_ferr), .overrun_err(l_oerr), .busy(l_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of sampled bits; words are assembled arithmetically.
  bit           md_in_frame;
  int           md_bits[$];
  logic [W-1:0] md_dm, md_dl;
  bit           md_v, md_f, md_o;

  task automatic model_reset();
    md_in_frame = 0;
    md_bits.delete();
    md_dm = '0;
    md_dl = '0;
    md_v  = 0;
    md_f  = 0;
    md_o  = 0;
  endtask

  task automatic model_step(input logic sin, input logic en, input logic rdy, input logic clr);
    bit nv, nf, no;
    logic [W-1:0] wm, wl;
    nv = md_v && !rdy;
    nf = clr ? 1'b0 : md_f;
    no = clr ? 1'b0 : md_o;
    if (en) begin
      if (!md_in_frame) begin
        if (sin == 1'b0) begin
          md_in_frame = 1;
          md_bits.delete();
        end
      end else if (md_bits.size() < W) begin
        md_bits.push_back(int'(sin));
      end else begin
        md_in_frame = 0;
        if (sin == 1'b1) begin
          if (!md_v || rdy) begin
            wm = '0;
            wl = '0;
            for (int i = 0; i < W; i++) begin
              if (md_bits[i] != 0) begin
                wm = wm | (W'(1) << (W - 1 - i));
                wl = wl | (W'(1) << i);
              end
            end
            md_dm = wm;
            md_dl = wl;
            nv    = 1;
          end else begin
            no = 1;
          end
        end else begin
          nf = 1;
        end
      end
    end
    md_v = nv;
    md_f = nf;
    md_o = no;
  endtask

  task automatic check_model();
    chk("m_data",  32'(m_data),  32'(md_dm));
    chk("l_data",  32'(l_data),  32'(md_dl));
    chk("m_valid", 32'(m_valid), 32'(md_v));
    chk("l_valid", 32'(l_valid), 32'(md_v));
    chk("m_ferr",  32'(m_ferr),  32'(md_f));
    chk("l_ferr",  32'(l_ferr),  32'(md_f));
    chk("m_oerr",  32'(m_oerr),  32'(md_o));
    chk("l_oerr",  32'(l_oerr),  32'(md_o));
    chk("m_busy",  32'(m_busy),  32'(md_in_frame));
    chk("l_busy",  32'(l_busy),  32'(md_in_frame));
  endtask

  task automatic cyc(input logic sin, input logic en, input logic rdy, input logic clr);
    @(negedge clock);
    serial_in = sin;
    bit_en    = en;
    ready     = rdy;
    err_clear = clr;
    @(posedge clock);
    model_step(sin, en, rdy, clr);
    #1;
    check_model();
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    repeat (3) cyc(b, 1'b0, 1'b0, 1'b0);
    cyc(b, 1'b1, rdy, 1'b0);
  endtask

  // seq[7] is the first data bit on the line.
  task automatic send_frame(input logic [W-1:0] seq, input logic stop, input logic rdy);
    send_bit(1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) send_bit(seq[i], 1'b0);
    send_bit(stop, rdy);
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] seq;
    logic         stop;
    logic         rdy;
    logic         drain;
    logic [W-1:0] em;
    logic [W-1:0] el;
    logic         ev;
    logic         ef;
    logic         eo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"a5",      8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"one_lsb", 8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"framing", 8'h5A, 1'b0, 1'b0, 1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"3c",      8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"overrun", 8'hC3, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{"3c_again",8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"c3_ready",8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 8'hC3, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{"12",      8'h12, 1'b1, 1'b0, 1'b1, 8'h12, 8'h48, 1'b1, 1'b0, 1'b0};

    reset_L   = 1'b0;
    serial_in = 1'b1;
    bit_en    = 1'b0;
    ready     = 1'b0;
    err_clear = 1'b0;
    model_reset();
    #1;
    check_model();
    repeat (2) @(negedge clock);
    reset_L = 1'b1;

    foreach (vecs[k]) begin
      send_frame(vecs[k].seq, vecs[k].stop, vecs[k].rdy);
      chk({vecs[k].name, "_mdata"}, 32'(m_data),      32'(vecs[k].em));
      chk({vecs[k].name, "_ldata"}, 32'(l_data),      32'(vecs[k].el));
      chk({vecs[k].name, "_valid"}, 32'(m_valid),     32'(vecs[k].ev));
      chk({vecs[k].name, "_ferr"},  32'(m_ferr),      32'(vecs[k].ef));
      chk({vecs[k].name, "_oerr"},  32'(m_oerr),      32'(vecs[k].eo));
      if (vecs[k].drain) begin
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk({vecs[k].name, "_drain_valid"}, 32'(m_valid), 32'd0);
        chk({vecs[k].name, "_drain_ferr"},  32'(m_ferr),  32'd0);
        chk({vecs[k].name, "_drain_oerr"},  32'(m_oerr),  32'd0);
        chk({vecs[k].name, "_drain_data"},  32'(m_data),  32'(vecs[k].em));
      end
    end

    // Low line level only between strobes must not start a frame.
    for (int r = 0; r < 6; r++) begin
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("glitch_busy_m", 32'(m_busy), 32'd0);
      chk("glitch_busy_l", 32'(l_busy), 32'd0);
    end

    // Asynchronous reset after four data bits.
    send_frame(8'h77, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1), 1'b0);
    #2;
    reset_L = 1'b0;
    #1;
    chk("rst_mdata", 32'(m_data),  32'd0);
    chk("rst_ldata", 32'(l_data),  32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy",  32'(m_busy),  32'd0);
    chk("rst_ferr",  32'(m_ferr),  32'd0);
    chk("rst_oerr",  32'(m_oerr),  32'd0);
    model_reset();
    @(negedge clock);
    reset_L = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("after_rst_mdata", 32'(m_data),  32'h5A);
    chk("after_rst_ldata", 32'(l_data),  32'h5A);
    chk("after_rst_valid", 32'(m_valid), 32'd1);

    // Random line activity against the reference model.
    for (int c = 0; c < 3000; c++) begin
      cyc(1'($urandom_range(1)), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
          ($urandom_range(15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
